// File: rtl/i2c_poll_arbiter_if.sv
// Bus between the poll arbiter and the shared i2c_master engine.
// master: arbiter side, slave: i2c_master side.
interface i2c_poll_arbiter_if #(
   parameter int LENWIDTH = 4
);
   logic                m_req;
   logic [6:0]          m_addr;
   logic [LENWIDTH-1:0] m_len;
   logic                m_we;
   logic [31:0]         m_din;
   logic                m_ack;
   logic                m_err;
   logic                m_din_ack;
   logic                m_dout_dv;
   logic                m_dout_eop;
   logic [31:0]         m_dout;

   modport master (
      output m_req, m_addr, m_len, m_we, m_din,
      input  m_ack, m_err, m_din_ack, m_dout_dv, m_dout_eop, m_dout
   );

   modport slave (
      input  m_req, m_addr, m_len, m_we, m_din,
      output m_ack, m_err, m_din_ack, m_dout_dv, m_dout_eop, m_dout
   );
endinterface

// File: rtl/i2c_poll_arbiter.sv
// Shares one i2c_master between host commands and a periodic poller.
// Poller is compiled in only when I2C_POLL_ARB_POLL_EN is defined.
module i2c_poll_arbiter #(
   parameter int                  POLL_PERIOD = 125000,
   parameter logic [6:0]          POLL_ADDR   = 7'h48,
   parameter int                  LENWIDTH    = 4,
   parameter logic [LENWIDTH-1:0] POLL_LEN    = LENWIDTH'(1)
) (
   input  logic                c,
   input  logic                rst,
   input  logic                h_req,
   input  logic [6:0]          h_addr,
   input  logic [LENWIDTH-1:0] h_len,
   input  logic                h_we,
   input  logic [31:0]         h_din,
   output logic                h_din_ack,
   output logic [31:0]         h_dout,
   output logic                h_dout_dv,
   output logic                h_dout_eop,
   output logic                h_busy,
   output logic                h_done,
   output logic                h_err,
   input  logic                poll_en,
   output logic [31:0]         poll_data,
   output logic                poll_valid,
   output logic                poll_err,
   i2c_poll_arbiter_if.master  m
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BUSY  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                owner_q, owner_d;
   logic                last_q, last_d;
   logic                hpend_q, hpend_d;
   logic [6:0]          ha_q, ha_d;
   logic [LENWIDTH-1:0] hl_q, hl_d;
   logic                hw_q, hw_d;
   logic                req_q, req_d;
   logic [6:0]          ma_q, ma_d;
   logic [LENWIDTH-1:0] ml_q, ml_d;
   logic                mw_q, mw_d;
   logic                first_q, first_d;

   logic poll_pend;
   logic poll_take;
   logic done;
   logic host_own;
   logic poll_own;

   always_ff @(posedge c) begin
      if (rst) begin
         state_q <= S_IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         hpend_q <= 1'b0;
         ha_q    <= '0;
         hl_q    <= '0;
         hw_q    <= 1'b0;
         req_q   <= 1'b0;
         ma_q    <= '0;
         ml_q    <= '0;
         mw_q    <= 1'b0;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         hpend_q <= hpend_d;
         ha_q    <= ha_d;
         hl_q    <= hl_d;
         hw_q    <= hw_d;
         req_q   <= req_d;
         ma_q    <= ma_d;
         ml_q    <= ml_d;
         mw_q    <= mw_d;
         first_q <= first_d;
      end
   end

   // A stale m_err on the first BUSY cycle belongs to the previous transfer.
   assign done = (state_q == S_BUSY) &&
                 (m.m_ack || (m.m_err && !first_q));

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      hpend_d   = hpend_q;
      ha_d      = ha_q;
      hl_d      = hl_q;
      hw_d      = hw_q;
      req_d     = req_q;
      ma_d      = ma_q;
      ml_d      = ml_q;
      mw_d      = mw_q;
      first_d   = 1'b0;
      poll_take = 1'b0;
      if (h_req && !h_busy) begin
         hpend_d = 1'b1;
         ha_d    = h_addr;
         hl_d    = h_len;
         hw_d    = h_we;
      end
      unique case (state_q)
         S_IDLE: begin
            if (hpend_q || poll_pend) begin
               if (hpend_q && (!poll_pend || last_q)) begin
                  ma_d    = ha_q;
                  ml_d    = hl_q;
                  mw_d    = hw_q;
                  hpend_d = 1'b0;
                  owner_d = 1'b0;
                  last_d  = 1'b0;
               end else begin
                  ma_d      = POLL_ADDR;
                  ml_d      = POLL_LEN;
                  mw_d      = 1'b0;
                  poll_take = 1'b1;
                  owner_d   = 1'b1;
                  last_d    = 1'b1;
               end
               req_d   = 1'b1;
               first_d = 1'b1;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (done) begin
               req_d   = 1'b0;
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (!m.m_ack) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      host_own   = (state_q != S_IDLE) && !owner_q;
      poll_own   = (state_q != S_IDLE) && owner_q;
      h_busy     = hpend_q || host_own;
      h_done     = done && !owner_q && !rst;
      h_err      = h_done && m.m_err;
      h_din_ack  = host_own && m.m_din_ack;
      h_dout_dv  = host_own && m.m_dout_dv;
      h_dout_eop = host_own && m.m_dout_eop;
      h_dout     = host_own ? m.m_dout : 32'h0;
      m.m_din    = host_own ? h_din : 32'h0;
   end

   assign m.m_req  = req_q;
   assign m.m_addr = ma_q;
   assign m.m_len  = ml_q;
   assign m.m_we   = mw_q;

`ifdef I2C_POLL_ARB_POLL_EN
   localparam int TW = $clog2(POLL_PERIOD);

   logic [TW-1:0] tmr_q, tmr_d;
   logic          ppend_q, ppend_d;
   logic [31:0]   shadow_q, shadow_d;
   logic [31:0]   pdata_q, pdata_d;
   logic          wrap;
   logic          poll_fin;

   always_ff @(posedge c) begin
      if (rst) begin
         tmr_q    <= '0;
         ppend_q  <= 1'b0;
         shadow_q <= '0;
         pdata_q  <= '0;
      end else begin
         tmr_q    <= tmr_d;
         ppend_q  <= ppend_d;
         shadow_q <= shadow_d;
         pdata_q  <= pdata_d;
      end
   end

   always_comb begin
      tmr_d = tmr_q;
      wrap  = 1'b0;
      if (!poll_en) begin
         tmr_d = '0;
      end else if (tmr_q == TW'(POLL_PERIOD - 1)) begin
         tmr_d = '0;
         wrap  = 1'b1;
      end else begin
         tmr_d = tmr_q + 1'b1;
      end
      ppend_d = ppend_q;
      if (poll_take) ppend_d = 1'b0;
      if (wrap) ppend_d = 1'b1;
      shadow_d = shadow_q;
      if (poll_own && m.m_dout_dv) shadow_d = m.m_dout;
      poll_fin = done && owner_q && !rst;
      pdata_d  = pdata_q;
      if (poll_fin && !m.m_err) pdata_d = shadow_d;
   end

   assign poll_pend  = ppend_q;
   assign poll_data  = pdata_q;
   assign poll_valid = poll_fin;
   assign poll_err   = poll_fin && m.m_err;
`else
   logic unused_poll;

   assign unused_poll = ^{poll_en, poll_take, poll_own};
   assign poll_pend   = 1'b0;
   assign poll_data   = 32'h0;
   assign poll_valid  = 1'b0;
   assign poll_err    = 1'b0;
`endif
endmodule
